// File: rtl/ppr_pkg.sv
// Shared definitions for the random-walk blocks: scan FSM encoding and the
// counter-table row length (walk steps per start node times node count).
package ppr_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    ACC  = 3'd2,
    EMIT = 3'd3,
    FIN  = 3'd4
  } ppr_state_e;

  localparam int unsigned DEF_NODE_NUM  = 10;
  localparam int unsigned DEF_MAX_STEPS = 6;

  // One counter row holds every visit count recorded for a single node.
  function automatic int unsigned row_len(input int unsigned node_num,
                                          input int unsigned max_steps);
    return node_num * max_steps;
  endfunction

  localparam int unsigned DEF_ROW_LEN = row_len(DEF_NODE_NUM, DEF_MAX_STEPS);

endpackage

// File: rtl/sat_add.sv
// Unsigned adder that clamps to all-ones instead of wrapping on overflow.
module sat_add #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] sum_o
);

  logic [DATA_WIDTH:0] wide_sum;

  assign wide_sum = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o    = wide_sum[DATA_WIDTH] ? '1 : wide_sum[DATA_WIDTH-1:0];

endmodule

// File: rtl/ppr_score_reducer.sv
// Scans the random-walk counter table row by row, sums each node's visit
// counts into a score beat, optionally zeroes counters, and tracks the best node.
module ppr_score_reducer
  import ppr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH           = 13,
  parameter int unsigned DATA_WIDTH           = 32,
  parameter int unsigned counter_table_offset = 1000,
  parameter int unsigned max_steps            = DEF_MAX_STEPS,
  parameter int unsigned node_num             = DEF_NODE_NUM
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear_en,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  score_valid,
  input  logic                  score_ready,
  output logic [DATA_WIDTH-1:0] score_node,
  output logic [DATA_WIDTH-1:0] score_value,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] best_node,
  output logic [DATA_WIDTH-1:0] best_score
);

  localparam int unsigned L = row_len(node_num, max_steps);

  localparam logic [DATA_WIDTH-1:0] LAST_COL  = DATA_WIDTH'(L - 1);
  localparam logic [DATA_WIDTH-1:0] LAST_NODE = DATA_WIDTH'(node_num - 1);
  localparam logic [DATA_WIDTH-1:0] ROW_LEN_W = DATA_WIDTH'(L);
  localparam logic [DATA_WIDTH-1:0] OFFSET_W  = DATA_WIDTH'(counter_table_offset);

  ppr_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] node_q, node_d;
  logic [DATA_WIDTH-1:0] col_q, col_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] best_node_q, best_node_d;
  logic [DATA_WIDTH-1:0] best_score_q, best_score_d;
  logic                  clear_q, clear_d;

  logic [DATA_WIDTH-1:0] acc_sum;
  logic [DATA_WIDTH-1:0] addr_full;

  sat_add #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sat_add (
    .a_i  (acc_q),
    .b_i  (data_in),
    .sum_o(acc_sum)
  );

  // Full-width address, narrowed only at the port.
  assign addr_full = OFFSET_W + node_q * ROW_LEN_W + col_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      node_q       <= '0;
      col_q        <= '0;
      acc_q        <= '0;
      best_node_q  <= '0;
      best_score_q <= '0;
      clear_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      node_q       <= node_d;
      col_q        <= col_d;
      acc_q        <= acc_d;
      best_node_q  <= best_node_d;
      best_score_q <= best_score_d;
      clear_q      <= clear_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state term gets a default first so no latch is inferred.
    state_d      = state_q;
    node_d       = node_q;
    col_d        = col_q;
    acc_d        = acc_q;
    best_node_d  = best_node_q;
    best_score_d = best_score_q;
    clear_d      = clear_q;
    address      = '0;
    write_enable = 1'b0;
    score_valid  = 1'b0;
    score_node   = '0;
    score_value  = '0;
    done         = 1'b0;
    busy         = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          clear_d      = clear_en;
          node_d       = '0;
          col_d        = '0;
          acc_d        = '0;
          best_node_d  = '0;
          best_score_d = '0;
          state_d      = RD;
        end
      end

      RD: begin
        address = ADDR_WIDTH'(addr_full);
        state_d = ACC;
      end

      ACC: begin
        address = ADDR_WIDTH'(addr_full);
        // The zeroing write is suppressed combinationally so an abort never writes.
        write_enable = clear_q && !reset;
        acc_d        = acc_sum;
        if (col_q == LAST_COL) begin
          state_d = EMIT;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = RD;
        end
      end

      EMIT: begin
        score_valid = 1'b1;
        score_node  = node_q;
        score_value = acc_q;
        if (score_ready) begin
          // Strict compare: on a tie the earlier (lower) node index is kept.
          if (acc_q > best_score_q) begin
            best_node_d  = node_q;
            best_score_d = acc_q;
          end
          acc_d = '0;
          col_d = '0;
          if (node_q == LAST_NODE) begin
            state_d = FIN;
          end else begin
            node_d  = node_q + 1'b1;
            state_d = RD;
          end
        end
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign data_out   = '0;
  assign best_node  = best_node_q;
  assign best_score = best_score_q;

endmodule
